count4_arb: RTL

COUNT4_ARB -- requirements
Module: count4_arb

---
 rtl/count4_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/count4_arb.sv
// Two-requester round-robin arbiter that sequences clear/count runs on a shared
// 4-bit up-counter, with a sticky watchdog for counters that never reach length.
module count4_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [3:0] cnt_q,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] WD_LIMIT = 5'd18;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_owner;
  logic       r_last;
  logic [3:0] r_len;
  logic [4:0] r_wd;
  logic [1:0] r_gnt;
  logic [1:0] r_done;
  logic       r_busy;
  logic       r_err;

  logic       w_pick;
  logic       w_own_req;
  logic       w_at_len;
  logic       w_wd_hit;

  function automatic logic [1:0] f_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  assign w_own_req = r_owner ? req[1] : req[0];
  assign w_at_len  = (cnt_q == r_len);
  // Last RUN cycle before the watchdog count reaches its limit.
  assign w_wd_hit  = (r_wd == (WD_LIMIT - 5'd1));

  // With both requesting, the one not served last wins.
  always_comb begin
    w_pick = 1'b0;
    if (req == 2'b11) begin
      w_pick = ~r_last;
    end else if (req == 2'b10) begin
      w_pick = 1'b1;
    end
  end

  // Abort has priority over completion, completion over the watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req != 2'b00) w_next = S_CLEAR;
      S_CLEAR: w_next = w_own_req ? S_RUN : S_IDLE;
      S_RUN: begin
        if (!w_own_req) begin
          w_next = S_IDLE;
        end else if (w_at_len) begin
          w_next = S_DONE;
        end else if (w_wd_hit) begin
          w_next = S_IDLE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign cnt_clr = (r_state == S_CLEAR);
  assign cnt_en  = (r_state == S_RUN) && w_own_req && !w_at_len;
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign busy    = r_busy;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_len   <= 4'd0;
      r_wd    <= 5'd0;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_owner <= w_pick;
            r_len   <= w_pick ? len1 : len0;
            r_gnt   <= f_onehot(w_pick);
          end
        end
        S_CLEAR: begin
          r_wd <= 5'd0;
          if (!w_own_req) begin
            r_gnt  <= 2'b00;
            r_last <= r_owner;
          end
        end
        S_RUN: begin
          r_wd <= r_wd + 5'd1;
          if (w_next != S_RUN) begin
            r_gnt  <= 2'b00;
            r_last <= r_owner;
          end
          if (w_next == S_DONE) begin
            r_done <= f_onehot(r_owner);
          end
          if (w_own_req && !w_at_len && w_wd_hit) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
